mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter in front of the CPU-side
// physical memory request interface that feeds the bus splitter.
//
// Requester 0 is the CPU core and requester 1 is a second master, such as a
// DMA engine or a page-table walker. The winning request is registered and
// held stable downstream until m_ack, so the downstream side sees one clean
// transaction at a time.
//
// Ports
//   clock, reset             system clock, synchronous active-high reset
//   sN_cycle                 request valid from requester N, held until sN_ack
//   sN_paddr/access/data_out request payload from requester N
//   sN_data_in               read data for requester N; meaningful when sN_ack=1
//   sN_ack                   completion strobe to requester N, forwarded from m_ack
//   m_cycle                  downstream request valid
//   m_paddr/access/data_out  registered downstream payload
//   m_data_in, m_ack         downstream read data and completion strobe
//   grant                    one-hot current owner, for debug and monitoring

package execute;
  typedef enum logic [1:0] {
    ACCESS_NONE = 2'd0,
    LOAD        = 2'd1,
    STORE       = 2'd2,
    EXECUTE     = 2'd3
  } memory_access_t;
endpackage

module mem_arbiter #(
  parameter int PLEN = 32,
  parameter int XLEN = 32
) (
  input  logic                   clock,
  input  logic                   reset,

  input  logic                   s0_cycle,
  input  logic [PLEN-1:0]        s0_paddr,
  input  execute::memory_access_t s0_access,
  input  logic [XLEN-1:0]        s0_data_out,
  output logic [4*XLEN-1:0]      s0_data_in,
  output logic                   s0_ack,

  input  logic                   s1_cycle,
  input  logic [PLEN-1:0]        s1_paddr,
  input  execute::memory_access_t s1_access,
  input  logic [XLEN-1:0]        s1_data_out,
  output logic [4*XLEN-1:0]      s1_data_in,
  output logic                   s1_ack,

  output logic                   m_cycle,
  output logic [PLEN-1:0]        m_paddr,
  output execute::memory_access_t m_access,
  output logic [XLEN-1:0]        m_data_out,
  input  logic [4*XLEN-1:0]      m_data_in,
  input  logic                   m_ack,

  output logic [1:0]             grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t                  state_p1;
  state_t                  state_p0;
  logic                    last_served_p1;
  logic                    last_served_p0;
  logic                    take0_p0;
  logic                    take1_p0;

  logic [PLEN-1:0]         req_paddr_p1;
  execute::memory_access_t req_access_p1;
  logic [XLEN-1:0]         req_data_p1;

  // ---- stage p0: arbitration decision from the live request lines ----
  // On a tie the requester that was not served last wins; last_served
  // resets to 1 so the CPU core takes the first tie.
  always_comb begin
    state_p0       = state_p1;
    last_served_p0 = last_served_p1;
    take0_p0       = 1'b0;
    take1_p0       = 1'b0;
    case (state_p1)
      IDLE: begin
        if (s0_cycle && (!s1_cycle || last_served_p1)) begin
          take0_p0       = 1'b1;
          state_p0       = BUSY0;
          last_served_p0 = 1'b0;
        end else if (s1_cycle) begin
          take1_p0       = 1'b1;
          state_p0       = BUSY1;
          last_served_p0 = 1'b1;
        end
      end
      BUSY0, BUSY1: begin
        // The owner may drop its cycle mid-transaction; the transaction
        // still stays open until the downstream ack arrives.
        if (m_ack) begin
          state_p0 = IDLE;
        end
      end
      default: begin
        state_p0 = IDLE;
      end
    endcase
  end

  // ---- stage p1: registered owner and frozen downstream request ----
  // The payload registers are cleared by reset too, so the downstream bus
  // shows a known request after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_p1       <= IDLE;
      last_served_p1 <= 1'b1;
      req_paddr_p1   <= '0;
      req_access_p1  <= execute::ACCESS_NONE;
      req_data_p1    <= '0;
    end else begin
      state_p1       <= state_p0;
      last_served_p1 <= last_served_p0;
      if (take0_p0) begin
        req_paddr_p1  <= s0_paddr;
        req_access_p1 <= s0_access;
        req_data_p1   <= s0_data_out;
      end else if (take1_p0) begin
        req_paddr_p1  <= s1_paddr;
        req_access_p1 <= s1_access;
        req_data_p1   <= s1_data_out;
      end
    end
  end

  // m_cycle comes straight from the state register, so there is no
  // combinational path from the request lines to the downstream bus.
  // Returning to IDLE after each ack gives the one-cycle bubble.
  assign m_cycle    = (state_p1 != IDLE);
  assign m_paddr    = req_paddr_p1;
  assign m_access   = req_access_p1;
  assign m_data_out = req_data_p1;
  assign grant      = {state_p1 == BUSY1, state_p1 == BUSY0};

  // The ack and read data go back in the same cycle, to the owner only.
  // An ack while IDLE matches no owner and is dropped.
  assign s0_ack     = (state_p1 == BUSY0) && m_ack;
  assign s1_ack     = (state_p1 == BUSY1) && m_ack;
  assign s0_data_in = (state_p1 == BUSY0) ? m_data_in : '0;
  assign s1_data_in = (state_p1 == BUSY1) ? m_data_in : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int PLEN = 32;
  localparam int XLEN = 32;

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    cyc      [2];
  logic [PLEN-1:0]         paddr    [2];
  execute::memory_access_t access   [2];
  logic [XLEN-1:0]         data_out [2];
  logic [4*XLEN-1:0]       s0_data_in, s1_data_in;
  logic                    s0_ack, s1_ack;
  logic                    m_cycle;
  logic [PLEN-1:0]         m_paddr;
  execute::memory_access_t m_access;
  logic [XLEN-1:0]         m_data_out;
  logic [4*XLEN-1:0]       m_data_in;
  logic                    m_ack;
  logic [1:0]              grant;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: who owns the bus, who was served last, and the
  // request captured when ownership was handed out.
  int                      owner;
  int                      last;
  logic [PLEN-1:0]         e_paddr;
  execute::memory_access_t e_access;
  logic [XLEN-1:0]         e_data;

  mem_arbiter #(.PLEN(PLEN), .XLEN(XLEN)) dut (
    .clock       (clock),
    .reset       (reset),
    .s0_cycle    (cyc[0]),
    .s0_paddr    (paddr[0]),
    .s0_access   (access[0]),
    .s0_data_out (data_out[0]),
    .s0_data_in  (s0_data_in),
    .s0_ack      (s0_ack),
    .s1_cycle    (cyc[1]),
    .s1_paddr    (paddr[1]),
    .s1_access   (access[1]),
    .s1_data_out (data_out[1]),
    .s1_data_in  (s1_data_in),
    .s1_ack      (s1_ack),
    .m_cycle     (m_cycle),
    .m_paddr     (m_paddr),
    .m_access    (m_access),
    .m_data_out  (m_data_out),
    .m_data_in   (m_data_in),
    .m_ack       (m_ack),
    .grant       (grant)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the model, mid-cycle.
  task automatic half_a();
    logic [1:0] eg;
    @(negedge clock);
    eg = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    check("m_cycle", m_cycle, owner >= 0);
    check("grant", grant, eg);
    check("s0_ack", s0_ack, owner == 0 && m_ack);
    check("s1_ack", s1_ack, owner == 1 && m_ack);
    check("one_ack", s0_ack && s1_ack, 1'b0);
    if (m_ack) begin
      check("s0_data_in", s0_data_in, (owner == 0) ? m_data_in : 128'h0);
      check("s1_data_in", s1_data_in, (owner == 1) ? m_data_in : 128'h0);
    end
    if (owner >= 0) begin
      check("m_paddr", m_paddr, e_paddr);
      check("m_access", m_access, e_access);
      check("m_data_out", m_data_out, e_data);
    end
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic half_b();
    @(posedge clock);
    if (reset) begin
      owner = -1;
      last  = 1;
    end else if (owner < 0) begin
      int w;
      w = -1;
      if (cyc[0] && cyc[1]) w = 1 - last;
      else if (cyc[0])      w = 0;
      else if (cyc[1])      w = 1;
      if (w >= 0) begin
        owner    = w;
        last     = w;
        e_paddr  = paddr[w];
        e_access = access[w];
        e_data   = data_out[w];
      end
    end else if (m_ack) begin
      owner = -1;
    end
    #1;
  endtask

  task automatic step();
    half_a();
    half_b();
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      cyc[i]      = 1'b0;
      paddr[i]    = '0;
      access[i]   = execute::ACCESS_NONE;
      data_out[i] = '0;
    end
    m_ack     = 1'b0;
    m_data_in = '0;
  endtask

  initial begin
    owner = -1;
    last  = 1;
    e_paddr = '0;
    e_access = execute::ACCESS_NONE;
    e_data = '0;
    clear_inputs();
    reset = 1'b1;
    half_b();
    half_b();
    reset = 1'b0;

    // Reset state
    half_a();
    check("rst_m_cycle", m_cycle, 1'b0);
    check("rst_grant", grant, 2'b00);
    check("rst_m_paddr", m_paddr, 32'h0);
    check("rst_m_access", m_access, execute::ACCESS_NONE);
    half_b();

    // Single requester, load, ack four cycles after the request
    cyc[0] = 1'b1; paddr[0] = 32'h8000_0040; access[0] = execute::LOAD;
    step();
    half_a();
    check("single_m_cycle", m_cycle, 1'b1);
    check("single_m_paddr", m_paddr, 32'h8000_0040);
    check("single_grant", grant, 2'b01);
    half_b();
    step();
    step();
    m_ack = 1'b1; m_data_in = {96'h0, 32'hDEAD_BEEF};
    half_a();
    check("single_s0_ack", s0_ack, 1'b1);
    check("single_word0", s0_data_in[31:0], 32'hDEAD_BEEF);
    check("single_s1_ack", s1_ack, 1'b0);
    half_b();
    clear_inputs();
    half_a();
    check("single_bubble", m_cycle, 1'b0);
    half_b();

    // Simultaneous first request after reset: requester 0 wins the tie
    reset = 1'b1; step(); reset = 1'b0;
    cyc[0] = 1'b1; cyc[1] = 1'b1; paddr[0] = 32'h10; paddr[1] = 32'h20;
    step();
    m_ack = 1'b1;
    half_a();
    check("tie_first", grant, 2'b01);
    half_b();
    m_ack = 1'b0; cyc[0] = 1'b0;
    half_a();
    check("tie_bubble", m_cycle, 1'b0);
    half_b();
    m_ack = 1'b1;
    half_a();
    check("tie_second", grant, 2'b10);
    half_b();
    clear_inputs();
    step();

    // Fairness: both hold cycle, ack two cycles after each grant
    cyc[0] = 1'b1; cyc[1] = 1'b1;
    for (int t = 0; t < 6; t++) begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        half_a();
        if (m_cycle) begin
          seen = 1'b1;
          check("fair_order", grant, (t % 2 == 0) ? 2'b01 : 2'b10);
        end
        half_b();
      end
      if (!seen) check("fair_wait", 1'b0, 1'b1);
      step();
      m_ack = 1'b1;
      step();
      m_ack = 1'b0;
    end
    clear_inputs();
    step();
    step();

    // Stability: payload changes while BUSY0 are ignored
    cyc[0] = 1'b1; paddr[0] = 32'h100; access[0] = execute::LOAD;
    step();
    paddr[0] = 32'h200;
    for (int k = 0; k < 3; k++) begin
      half_a();
      check("stable_paddr", m_paddr, 32'h100);
      half_b();
    end
    m_ack = 1'b1;
    step();
    clear_inputs();
    step();

    // Stray ack in IDLE, then reset in the middle of a BUSY1 transaction
    m_ack = 1'b1;
    half_a();
    check("stray_s0", s0_ack, 1'b0);
    check("stray_s1", s1_ack, 1'b0);
    half_b();
    m_ack = 1'b0;
    cyc[1] = 1'b1; paddr[1] = 32'h400;
    step();
    step();
    reset = 1'b1; cyc[1] = 1'b0;
    step();
    reset = 1'b0; m_ack = 1'b1;
    half_a();
    check("rst_busy_cycle", m_cycle, 1'b0);
    check("rst_busy_grant", grant, 2'b00);
    check("rst_busy_ack", s1_ack, 1'b0);
    half_b();
    m_ack = 1'b0; cyc[0] = 1'b1; cyc[1] = 1'b1;
    step();
    m_ack = 1'b1;
    half_a();
    check("rst_last_served", grant, 2'b01);
    half_b();
    clear_inputs();
    step();

    // Write path from requester 1
    cyc[1] = 1'b1; paddr[1] = 32'h1000; access[1] = execute::STORE;
    data_out[1] = 32'h1234_5678;
    step();
    half_a();
    check("wr_access", m_access, execute::STORE);
    check("wr_data", m_data_out, 32'h1234_5678);
    check("wr_paddr", m_paddr, 32'h1000);
    half_b();
    m_ack = 1'b1;
    half_a();
    check("wr_s1_ack", s1_ack, 1'b1);
    half_b();
    clear_inputs();
    step();

    // Randomized traffic, including protocol violations and resets
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 2; i++) begin
        cyc[i]      = ($urandom_range(0, 3) != 0);
        paddr[i]    = $urandom;
        access[i]   = execute::memory_access_t'($urandom_range(0, 3));
        data_out[i] = $urandom;
      end
      m_ack     = ($urandom_range(0, 2) == 0);
      m_data_in = {$urandom, $urandom, $urandom, $urandom};
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
